// File: rtl/serial_sub_ctrl_if.sv
// Request/result bus of the bit-serial subtraction controller.
// The master issues start with operands and observes busy/done and the result.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial N-bit subtraction controller: walks an external 1-bit full-subtractor
// cell LSB-first over the captured operands to produce a - b - bin.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_sub_ctrl_if.slave    bus,
    output logic                fs_a,
    output logic                fs_b,
    output logic                fs_bin,
    input  logic                fs_d,
    input  logic                fs_bout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic [WIDTH-1:0] res_next;

    // The cell only sees live operand bits while running; busy_r is a registered RUN flag.
    assign fs_a   = busy_r & a_sr[0];
    assign fs_b   = busy_r & b_sr[0];
    assign fs_bin = busy_r & brw;

    // The newest difference bit enters at the top so the first (LSB) bit ends up at bit 0.
    assign res_next = {fs_d, res_sr};

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.diff       = diff_r;
    assign bus.borrow_out = borrow_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            brw      <= 1'b0;
            cnt      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        brw    <= bus.bin;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    res_sr <= res_next[WIDTH-1:1];
                    brw    <= fs_bout;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + 1'b1;
                    // Last bit: publish the result and borrow together with the done pulse.
                    if (cnt == CW'(WIDTH - 1)) begin
                        diff_r   <= res_next;
                        borrow_r <= fs_bout;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl at WIDTH=8 with a behavioural full-subtractor cell.
module tb_serial_sub_ctrl;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    logic fs_a;
    logic fs_b;
    logic fs_bin;
    logic fs_d;
    logic fs_bout;

    int errors = 0;
    int checks = 0;

    serial_sub_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .fs_a    (fs_a),
        .fs_b    (fs_b),
        .fs_bin  (fs_bin),
        .fs_d    (fs_d),
        .fs_bout (fs_bout)
    );

    // External cell: D = A^B^Bin, Bout = ~A&B | ~(A^B)&Bin
    assign fs_d    = fs_a ^ fs_b ^ fs_bin;
    assign fs_bout = (~fs_a & fs_b) | (~(fs_a ^ fs_b) & fs_bin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] av,
                                 input logic [WIDTH-1:0] bv, input logic bi);
        bus.start = s;
        bus.a     = av;
        bus.b     = bv;
        bus.bin   = bi;
    endtask

    // Issue a request and follow it to its done cycle; leaves the bench in that cycle.
    // A nonzero glitchCycle pulses start with other operands during that RUN cycle.
    task automatic runOp(input string tag, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, input logic bi,
                         input logic [WIDTH-1:0] prevDiff, input logic prevBorrow,
                         input logic [WIDTH-1:0] expDiff, input logic expBorrow,
                         input int glitchCycle);
        int cyc;
        applyStimulus(1'b1, av, bv, bi);
        tick();
        applyStimulus(1'b0, av, bv, bi);
        cyc = 1;
        checkOutput({tag, " busy c1"}, 32'(bus.busy), 32'd1);
        checkOutput({tag, " diff held c1"}, 32'(bus.diff), 32'(prevDiff));
        checkOutput({tag, " borrow held c1"}, 32'(bus.borrow_out), 32'(prevBorrow));
        checkOutput({tag, " fs lsb c1"}, {29'd0, fs_a, fs_b, fs_bin}, {29'd0, av[0], bv[0], bi});
        while (!bus.done && cyc < 20) begin
            if (cyc == glitchCycle) applyStimulus(1'b1, 8'h01, 8'h01, 1'b0);
            tick();
            if (cyc == glitchCycle) applyStimulus(1'b0, av, bv, bi);
            cyc++;
        end
        checkOutput({tag, " done seen"}, 32'(bus.done), 32'd1);
        checkOutput({tag, " latency"}, 32'(cyc), 32'd9);
        checkOutput({tag, " diff"}, 32'(bus.diff), 32'(expDiff));
        checkOutput({tag, " borrow"}, 32'(bus.borrow_out), 32'(expBorrow));
        checkOutput({tag, " busy in done"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int doneSeen;
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset diff", 32'(bus.diff), 32'd0);
        checkOutput("reset borrow", 32'(bus.borrow_out), 32'd0);
        checkOutput("reset fs", {29'd0, fs_a, fs_b, fs_bin}, 32'd0);
        rst = 1'b0;
        tick();

        // Stray start at RUN cycle 3 must not disturb the running operation.
        runOp("op35m12", 8'h35, 8'h12, 1'b0, 8'h00, 1'b0, 8'h23, 1'b0, 3);
        // Start presented in the done cycle chains straight into the next operation.
        runOp("b2b80m01", 8'h80, 8'h01, 1'b0, 8'h23, 1'b0, 8'h7F, 1'b0, 0);
        tick();
        checkOutput("idle after done", {30'd0, bus.busy, bus.done}, 32'd0);
        checkOutput("diff holds idle", 32'(bus.diff), 32'h7F);

        runOp("op00m00b1", 8'h00, 8'h00, 1'b1, 8'h7F, 1'b0, 8'hFF, 1'b1, 0);
        runOp("opFFmFF", 8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 0);
        runOp("op12m35", 8'h12, 8'h35, 1'b0, 8'h00, 1'b0, 8'hDD, 1'b1, 0);
        tick();

        // Abort mid-operation: reset during RUN cycle 4.
        applyStimulus(1'b1, 8'h35, 8'h12, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h35, 8'h12, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("abort busy before rst", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        checkOutput("abort done", 32'(bus.done), 32'd0);
        checkOutput("abort diff", 32'(bus.diff), 32'd0);
        checkOutput("abort borrow", 32'(bus.borrow_out), 32'd0);
        checkOutput("abort fs", {29'd0, fs_a, fs_b, fs_bin}, 32'd0);
        doneSeen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done || bus.busy) doneSeen++;
        end
        checkOutput("abort no done", 32'(doneSeen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
